// File: rtl/x83_frame_acc_if.sv
// Valid/ready bus for the x83 frame accumulator.
// Input side: in_valid/in_ready/in_data (unsigned products).
// Output side: out_valid/out_ready/out_data/out_sat (frame results).
// master: the environment that produces products and consumes results.
// slave: the accumulator itself.
interface x83_frame_acc_if #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_sat;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sat
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sat
    );
endinterface

// File: rtl/x83_frame_acc.sv
// Frame accumulator for x83-scaled products: sums FRAME_LEN
// products, then rounds (half up), shifts right by SHIFT and
// saturates to OUT_W bits; the result waits in a register until
// the consumer takes it.
// Ports: clk (rising edge), rst (sync, active high),
//        clr (aborts the partial frame while accumulating),
//        bus (x83_frame_acc_if.slave: input and output handshakes).
module x83_frame_acc #(
    parameter int IN_W      = 24,
    parameter int FRAME_LEN = 8,
    parameter int SHIFT     = 3,
    parameter int OUT_W     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    x83_frame_acc_if.slave bus
);
    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam int ACC_W = IN_W + CNT_W;

    // Half an output LSB, added before the shift for round-half-up.
    localparam logic [ACC_W:0] HALF =
        {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);

    typedef enum logic {
        S_ACC  = 1'b0,
        S_DONE = 1'b1
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             out_valid_q;
    logic [OUT_W-1:0] out_data_q;
    logic             out_sat_q;

    logic [ACC_W-1:0] sum;
    logic [ACC_W:0]   rnd;
    logic [ACC_W:0]   shr;
    logic             sat;
    logic [OUT_W-1:0] res;
    logic             last;
    logic             accept;

    // in_ready never looks at in_valid, so upstream can wait on it.
    assign bus.in_ready  = (state == S_ACC) && !clr;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign last   = (count == CNT_W'(FRAME_LEN - 1));

    // ACC_W holds FRAME_LEN full-scale products; the rounding add
    // gets one extra bit so that it cannot wrap either.
    always_comb begin
        sum = acc + {{CNT_W{1'b0}}, bus.in_data};
        rnd = {1'b0, sum} + HALF;
        shr = rnd >> SHIFT;
        sat = |shr[ACC_W:OUT_W];
        res = sat ? {OUT_W{1'b1}} : shr[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_ACC;
            acc         <= '0;
            count       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            unique case (state)
                S_ACC: begin
                    if (clr) begin
                        acc   <= '0;
                        count <= '0;
                    end else if (accept) begin
                        if (last) begin
                            acc         <= '0;
                            count       <= '0;
                            out_data_q  <= res;
                            out_sat_q   <= sat;
                            out_valid_q <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            acc   <= sum;
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    // clr is ignored here so a finished result survives.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= S_ACC;
                    end
                end
                default: begin
                    state <= S_ACC;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_x83_frame_acc.sv
// Directed bench for x83_frame_acc: table of frames with
// hand-computed results plus backpressure, clr and reset sequences.
module tb_x83_frame_acc;
    logic clk;
    logic rst;
    logic clr;

    x83_frame_acc_if #(.IN_W(24), .OUT_W(16)) bus ();

    x83_frame_acc #(
        .IN_W(24),
        .FRAME_LEN(8),
        .SHIFT(3),
        .OUT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [23:0] d [8];
        logic [15:0] exp_d;
        logic        exp_s;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t vecs [12];

    function automatic vec_t mk(string n, logic [23:0] a,
                                logic [23:0] b, logic [23:0] rest,
                                logic [15:0] e, logic s);
        vec_t v;
        v.name = n;
        v.d[0] = a;
        v.d[1] = b;
        for (int i = 2; i < 8; i++) v.d[i] = rest;
        v.exp_d = e;
        v.exp_s = s;
        return v;
    endfunction

    task automatic chk(string n, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", n, act, exp);
        end
    endtask

    // Present one product and hold it until accepted (bounded).
    task automatic push(logic [23:0] d);
        int b;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        #1;
        b = 0;
        while (!bus.in_ready && b < 20) begin
            @(posedge clk);
            #2;
            b++;
        end
        if (b >= 20) begin
            checks++;
            errors++;
            $display("FAIL push_timeout got=0 want=1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic feed(vec_t v);
        for (int i = 0; i < 8; i++) push(v.d[i]);
        bus.in_valid = 1'b0;
    endtask

    // Called one cycle after the last accept with out_ready=1.
    task automatic check_done(vec_t v);
        #1;
        chk({v.name, "_valid"}, bus.out_valid, 1);
        chk({v.name, "_data"}, bus.out_data, v.exp_d);
        chk({v.name, "_sat"}, bus.out_sat, v.exp_s);
        chk({v.name, "_busy"}, bus.in_ready, 0);
        @(posedge clk);
        #1;
        chk({v.name, "_drained"}, bus.out_valid, 0);
        chk({v.name, "_ready"}, bus.in_ready, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk("nom83", 83, 83, 83, 83, 0);
        vecs[1]  = mk("rnd4", 4, 0, 0, 1, 0);
        vecs[2]  = mk("rnd3", 3, 0, 0, 0, 0);
        vecs[3]  = mk("rnd11_1", 11, 1, 0, 2, 0);
        vecs[4]  = mk("rnd11", 11, 0, 0, 1, 0);
        vecs[5]  = mk("rnd12", 12, 0, 0, 2, 0);
        vecs[6]  = mk("sat83k", 83000, 83000, 83000, 16'hffff, 1);
        vecs[7]  = mk("satmax", 24'hffffff, 24'hffffff, 24'hffffff,
                      16'hffff, 1);
        vecs[8]  = mk("edge65535", 65535, 65535, 65535, 65535, 0);
        vecs[9]  = mk("edge65536", 65536, 65536, 65536, 16'hffff, 1);
        vecs[10] = mk("zero", 0, 0, 0, 0, 0);
        vecs[11] = mk("mix", 7, 7, 0, 2, 0);

        rst = 1'b1;
        clr = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) begin
            bus.in_valid  = 1'($urandom);
            bus.in_data   = 24'($urandom);
            bus.out_ready = 1'($urandom);
            clr           = 1'($urandom);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        clr = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_sat", bus.out_sat, 0);
        chk("rst_ready", bus.in_ready, 1);

        foreach (vecs[i]) begin
            bus.out_ready = 1'b1;
            feed(vecs[i]);
            check_done(vecs[i]);
        end

        // Backpressure: result held, nothing absorbed meanwhile.
        bus.out_ready = 1'b0;
        feed(mk("bp", 100, 100, 100, 100, 0));
        bus.in_valid = 1'b1;
        bus.in_data  = 24'd5000;
        repeat (5) begin
            #1;
            chk("bp_valid", bus.out_valid, 1);
            chk("bp_data", bus.out_data, 100);
            chk("bp_busy", bus.in_ready, 0);
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_drained", bus.out_valid, 0);
        feed(mk("bp_next", 8, 8, 8, 8, 0));
        check_done(mk("bp_next", 8, 8, 8, 8, 0));

        // clr mid-frame discards the partial sum and its own product.
        for (int i = 0; i < 5; i++) push(100);
        clr = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 24'd100;
        #1;
        chk("clr_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        bus.in_valid = 1'b0;
        feed(mk("after_clr", 8, 8, 8, 8, 0));
        check_done(mk("after_clr", 8, 8, 8, 8, 0));

        // Same with rst in place of clr.
        for (int i = 0; i < 5; i++) push(100);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 24'd100;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_mid_valid", bus.out_valid, 0);
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        feed(mk("after_rst", 8, 8, 8, 8, 0));
        check_done(mk("after_rst", 8, 8, 8, 8, 0));

        // clr while a result is pending must not drop it.
        bus.out_ready = 1'b0;
        feed(mk("clr_done", 83, 83, 83, 83, 0));
        clr = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("clr_done_valid", bus.out_valid, 1);
            chk("clr_done_data", bus.out_data, 83);
        end
        clr = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("clr_done_drained", bus.out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
